// File: rtl/leg_gate_monitor.sv
// leg_gate_monitor
// Read-back monitor for one half-bridge leg. The Q1/Q2 gate feedback pins
// are synchronized and glitch-filtered, then decoded into a leg state.
// The actual dead time is measured on every complementary transition.
// Sticky faults are raised for shoot-through, short dead time and
// command/feedback mismatch, and are held until fault_clear.

module leg_gate_monitor #(
  parameter int FILTER_COUNT     = 3,
  parameter int MIN_DEADTIME     = 4,
  parameter int MISMATCH_TIMEOUT = 16,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Q1_cmd,
  input  logic                 Q2_cmd,
  input  logic                 Q1_fb,
  input  logic                 Q2_fb,
  input  logic                 fault_clear,
  output logic                 Q1_filt,
  output logic                 Q2_filt,
  output logic [1:0]           leg_state,
  output logic [CNT_WIDTH-1:0] deadtime_meas,
  output logic                 deadtime_valid,
  output logic                 fault_shoot,
  output logic                 fault_deadtime,
  output logic                 fault_mismatch,
  output logic                 fault_any
);

  // Leg states use the same encoding as leg_state: {top on, bottom on}.
  localparam logic [1:0] ST_DEAD  = 2'b00;
  localparam logic [1:0] ST_LOW   = 2'b01;
  localparam logic [1:0] ST_HIGH  = 2'b10;
  localparam logic [1:0] ST_SHOOT = 2'b11;

  // Which switch was conducting before the leg last went dead.
  localparam logic [1:0] LAST_NONE = 2'b00;
  localparam logic [1:0] LAST_LOW  = 2'b01;
  localparam logic [1:0] LAST_HIGH = 2'b10;

  localparam logic [3:0]           FILT_LAST = 4'(FILTER_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] MIN_DT    = CNT_WIDTH'(MIN_DEADTIME);
  localparam logic [CNT_WIDTH-1:0] MM_LIMIT  = CNT_WIDTH'(MISMATCH_TIMEOUT);

  // Bit 1 carries the top switch (Q1), bit 0 the bottom switch (Q2).
  logic [1:0] fb_pin;
  logic [1:0] cmd_vec;
  logic [1:0] filt_q_vec;
  logic [1:0] filt_d_vec;

  assign fb_pin  = {Q1_fb, Q2_fb};
  assign cmd_vec = {Q1_cmd, Q2_cmd};

  // ---------------------------------------------------------------------
  // Per-pin synchronizer and glitch filter
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_fb
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // Two-flop synchronizer, then a hold counter: the filtered level only
    // follows once the synced level has differed for FILTER_COUNT cycles.
    always_comb begin
      sync1_d = fb_pin[gi];
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = cnt_q;
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == FILT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    // Synchronizer and filter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        filt_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
      end
    end

    assign filt_q_vec[gi] = filt_q;
    assign filt_d_vec[gi] = filt_d;
  end

  // ---------------------------------------------------------------------
  // Leg state, dead-time measurement, mismatch timer and faults
  // ---------------------------------------------------------------------
  logic [1:0]           state_q, state_d;
  logic [1:0]           last_on_q, last_on_d;
  logic [CNT_WIDTH-1:0] dt_q, dt_d;
  logic [CNT_WIDTH-1:0] dt_inc;
  logic [CNT_WIDTH-1:0] meas_q, meas_d;
  logic                 valid_q, valid_d;
  logic                 dt_short;
  logic [CNT_WIDTH-1:0] mm_q, mm_d;
  logic [CNT_WIDTH-1:0] mm_inc;
  logic                 mm_active;
  logic                 mm_set;
  logic                 shoot_set;
  logic                 fault_shoot_q, fault_shoot_d;
  logic                 fault_dt_q, fault_dt_d;
  logic                 fault_mm_q, fault_mm_d;
  logic                 fault_any_q, fault_any_d;

  // The state tracks the next filtered levels so leg_state changes on the
  // same edge as Q1_filt/Q2_filt.
  always_comb begin
    state_d = filt_d_vec;
  end

  // Dead-time counting and measurement on complementary transitions.
  // The count includes the exit cycle, so a leg that sat dead for N cycles
  // reports N.
  always_comb begin
    dt_inc    = (dt_q == CNT_MAX) ? dt_q : dt_q + 1'b1;
    dt_d      = dt_q;
    meas_d    = meas_q;
    valid_d   = 1'b0;
    dt_short  = 1'b0;
    last_on_d = last_on_q;

    if (state_q == ST_DEAD) begin
      dt_d = dt_inc;
    end
    if ((state_d == ST_DEAD) && (state_q != ST_DEAD)) begin
      dt_d = '0;
    end

    case (state_d)
      ST_LOW:   last_on_d = LAST_LOW;
      ST_HIGH:  last_on_d = LAST_HIGH;
      ST_SHOOT: last_on_d = LAST_NONE;
      default:  last_on_d = last_on_q;
    endcase

    if ((state_q == ST_DEAD) &&
        (((state_d == ST_LOW)  && (last_on_q == LAST_HIGH)) ||
         ((state_d == ST_HIGH) && (last_on_q == LAST_LOW)))) begin
      // Genuine handover through a dead interval.
      meas_d   = dt_inc;
      valid_d  = 1'b1;
      dt_short = (dt_inc < MIN_DT);
    end else if (((state_q == ST_LOW)  && (state_d == ST_HIGH)) ||
                 ((state_q == ST_HIGH) && (state_d == ST_LOW))) begin
      // Handover with no dead cycle at all.
      meas_d   = '0;
      valid_d  = 1'b1;
      dt_short = 1'b1;
    end
  end

  // Mismatch timer: consecutive cycles where filtered feedback disagrees
  // with the command. The fault fires once, on the cycle the count arrives
  // at the limit, not on every saturated cycle afterwards.
  always_comb begin
    mm_active = (filt_q_vec != cmd_vec);
    mm_inc    = (mm_q == CNT_MAX) ? mm_q : mm_q + 1'b1;
    mm_d      = mm_active ? mm_inc : '0;
    mm_set    = mm_active && (mm_q != MM_LIMIT) && (mm_inc == MM_LIMIT);
  end

  // Sticky faults: a set condition beats fault_clear, and shoot-through
  // cannot be cleared while the leg is still shorted.
  always_comb begin
    shoot_set     = (state_d == ST_SHOOT);
    fault_shoot_d = shoot_set |
                    (fault_shoot_q & ~(fault_clear & (state_q != ST_SHOOT)));
    fault_dt_d    = dt_short | (fault_dt_q & ~fault_clear);
    fault_mm_d    = mm_set | (fault_mm_q & ~fault_clear);
    fault_any_d   = fault_shoot_q | fault_dt_q | fault_mm_q;
  end

  // State, counters, measurement and fault registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_DEAD;
      last_on_q     <= LAST_NONE;
      dt_q          <= '0;
      meas_q        <= '0;
      valid_q       <= 1'b0;
      mm_q          <= '0;
      fault_shoot_q <= 1'b0;
      fault_dt_q    <= 1'b0;
      fault_mm_q    <= 1'b0;
      fault_any_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_on_q     <= last_on_d;
      dt_q          <= dt_d;
      meas_q        <= meas_d;
      valid_q       <= valid_d;
      mm_q          <= mm_d;
      fault_shoot_q <= fault_shoot_d;
      fault_dt_q    <= fault_dt_d;
      fault_mm_q    <= fault_mm_d;
      fault_any_q   <= fault_any_d;
    end
  end

  assign Q1_filt        = filt_q_vec[1];
  assign Q2_filt        = filt_q_vec[0];
  assign leg_state      = state_q;
  assign deadtime_meas  = meas_q;
  assign deadtime_valid = valid_q;
  assign fault_shoot    = fault_shoot_q;
  assign fault_deadtime = fault_dt_q;
  assign fault_mismatch = fault_mm_q;
  assign fault_any      = fault_any_q;

endmodule

// File: tb/tb_leg_gate_monitor.sv
// tb_leg_gate_monitor
// Directed stimulus for leg_gate_monitor. Expected dead-time measurements
// are queued when a transition is driven; a separate monitor pops one on
// every deadtime_valid pulse. Other outputs are checked inline.

module tb_leg_gate_monitor;

  logic       CLK;
  logic       RST_N;
  logic       Q1_cmd, Q2_cmd, Q1_fb, Q2_fb;
  logic       fault_clear;
  logic       Q1_filt, Q2_filt;
  logic [1:0] leg_state;
  logic [7:0] deadtime_meas;
  logic       deadtime_valid;
  logic       fault_shoot, fault_deadtime, fault_mismatch, fault_any;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] meas;
    bit         short_dt;
  } exp_t;

  exp_t sb_q[$];

  leg_gate_monitor #(
    .FILTER_COUNT(3),
    .MIN_DEADTIME(4),
    .MISMATCH_TIMEOUT(16),
    .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .Q1_cmd(Q1_cmd),
    .Q2_cmd(Q2_cmd),
    .Q1_fb(Q1_fb),
    .Q2_fb(Q2_fb),
    .fault_clear(fault_clear),
    .Q1_filt(Q1_filt),
    .Q2_filt(Q2_filt),
    .leg_state(leg_state),
    .deadtime_meas(deadtime_meas),
    .deadtime_valid(deadtime_valid),
    .fault_shoot(fault_shoot),
    .fault_deadtime(fault_deadtime),
    .fault_mismatch(fault_mismatch),
    .fault_any(fault_any)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h at %0t", name, act, $time);
    end
  endtask

  // Feedback and command move together, as with a healthy gate driver.
  task automatic drive(input logic q1, input logic q2);
    Q1_fb  = q1;
    Q2_fb  = q2;
    Q1_cmd = q1;
    Q2_cmd = q2;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
  endtask

  // Scoreboard monitor: every deadtime_valid pulse must match the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && deadtime_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got meas %0d expected no pulse at %0t",
                   deadtime_meas, $time);
        end else begin
          e = sb_q.pop_front();
          check("deadtime_meas", 32'(deadtime_meas), 32'(e.meas));
          if (e.short_dt) check("fault_deadtime_on_pulse", 32'(fault_deadtime), 32'd1);
        end
      end
    end
  end

  initial begin
    RST_N       = 1'b0;
    fault_clear = 1'b0;
    drive(1'b0, 1'b0);

    // Reset state
    tick(3);
    check("rst_q1_filt", 32'(Q1_filt), 32'd0);
    check("rst_q2_filt", 32'(Q2_filt), 32'd0);
    check("rst_leg_state", 32'(leg_state), 32'd0);
    check("rst_meas", 32'(deadtime_meas), 32'd0);
    check("rst_valid", 32'(deadtime_valid), 32'd0);
    check("rst_faults", 32'({fault_shoot, fault_deadtime, fault_mismatch, fault_any}), 32'd0);
    RST_N = 1'b1;
    tick(50);
    check("idle_faults", 32'({fault_shoot, fault_deadtime, fault_mismatch, fault_any}), 32'd0);
    check("idle_leg_state", 32'(leg_state), 32'd0);

    // Normal handover HIGH -> 6 dead cycles -> LOW
    drive(1'b1, 1'b0);
    tick(4);
    check("latency_before", 32'(leg_state), 32'd0);
    tick(1);
    check("latency_high", 32'(leg_state), 32'd2);
    tick(15);
    drive(1'b0, 1'b0);
    tick(6);
    check("dead_state", 32'(leg_state), 32'd0);
    sb_q.push_back('{8'd6, 1'b0});
    drive(1'b0, 1'b1);
    tick(5);
    check("low_state", 32'(leg_state), 32'd1);
    tick(1);
    check("normal_no_fault", 32'({fault_shoot, fault_deadtime, fault_mismatch, fault_any}), 32'd0);
    tick(14);

    // Short dead time: LOW -> 2 dead cycles -> HIGH
    drive(1'b0, 1'b0);
    tick(2);
    sb_q.push_back('{8'd2, 1'b1});
    drive(1'b1, 1'b0);
    tick(5);
    check("short_high_state", 32'(leg_state), 32'd2);
    check("short_any_lag", 32'(fault_any), 32'd0);
    tick(1);
    check("short_any_set", 32'(fault_any), 32'd1);
    pulse_clear();
    check("short_dt_cleared", 32'(fault_deadtime), 32'd0);
    check("short_any_still", 32'(fault_any), 32'd1);
    tick(1);
    check("short_any_cleared", 32'(fault_any), 32'd0);
    tick(10);

    // Glitch filter on Q1 (leg dead, last side HIGH, so no measurement)
    drive(1'b0, 1'b0);
    tick(10);
    check("filt_dead", 32'(leg_state), 32'd0);
    Q1_fb = 1'b1;
    tick(2);
    Q1_fb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("pulse2_q1_filt", 32'(Q1_filt), 32'd0);
    end
    Q1_fb = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 3) Q1_fb = 1'b0;
      check($sformatf("pulse3_q1_filt_k%0d", k), 32'(Q1_filt),
            (k >= 5 && k <= 7) ? 32'd1 : 32'd0);
    end
    tick(5);

    // Direct HIGH -> LOW swap with no dead cycle
    drive(1'b1, 1'b0);
    tick(10);
    sb_q.push_back('{8'd0, 1'b1});
    drive(1'b0, 1'b1);
    tick(5);
    check("swap_low_state", 32'(leg_state), 32'd1);
    tick(1);
    check("swap_any_set", 32'(fault_any), 32'd1);
    pulse_clear();
    check("swap_dt_cleared", 32'(fault_deadtime), 32'd0);
    tick(2);

    // Shoot-through
    drive(1'b0, 1'b0);
    tick(10);
    drive(1'b1, 1'b1);
    tick(5);
    check("shoot_state", 32'(leg_state), 32'd3);
    check("shoot_fault", 32'(fault_shoot), 32'd1);
    pulse_clear();
    check("shoot_clear_blocked", 32'(fault_shoot), 32'd1);
    tick(4);
    drive(1'b0, 1'b0);
    tick(5);
    check("shoot_back_dead", 32'(leg_state), 32'd0);
    check("shoot_still_sticky", 32'(fault_shoot), 32'd1);
    pulse_clear();
    check("shoot_cleared", 32'(fault_shoot), 32'd0);
    tick(2);
    check("shoot_any_cleared", 32'(fault_any), 32'd0);

    // Command/feedback mismatch: 16 cycles faults, 15 does not
    Q1_cmd = 1'b1;
    tick(15);
    check("mm_15_no_fault", 32'(fault_mismatch), 32'd0);
    tick(1);
    check("mm_16_fault", 32'(fault_mismatch), 32'd1);
    Q1_cmd      = 1'b0;
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    check("mm_cleared", 32'(fault_mismatch), 32'd0);
    tick(1);
    Q1_cmd = 1'b1;
    tick(15);
    Q1_cmd = 1'b0;
    tick(3);
    check("mm_15_then_match", 32'(fault_mismatch), 32'd0);
    tick(2);
    check("mm_any_clear", 32'(fault_any), 32'd0);

    // Reset in the middle of a dead interval (last side LOW)
    drive(1'b0, 1'b1);
    tick(10);
    drive(1'b0, 1'b0);
    tick(8);
    RST_N = 1'b0;
    tick(2);
    check("midrst_leg_state", 32'(leg_state), 32'd0);
    check("midrst_faults", 32'({fault_shoot, fault_deadtime, fault_mismatch, fault_any}), 32'd0);
    RST_N = 1'b1;
    tick(3);
    drive(1'b1, 1'b0);
    tick(10);
    check("midrst_high_state", 32'(leg_state), 32'd2);
    check("midrst_meas_untouched", 32'(deadtime_meas), 32'd0);
    tick(5);

    check("sb_pending", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leg_gate_monitor.md
Name: leg_gate_monitor

Overview:
Monitors gate-drive feedback for one half-bridge leg, the read-back end of the complementary Q1/Q2 dead-time switch generator. It synchronizes and glitch-filters the top (Q1) and bottom (Q2) feedback pins, then decodes them into a leg state. It measures the actual dead time in clock cycles on every complementary transition. It raises sticky faults for shoot-through, short dead time, and command/feedback mismatch, feeding the inverter fault/trip logic.

Parameters:
FILTER_COUNT, 3, consecutive synchronized cycles a feedback input must hold a new level before the filtered output follows (1..15)
MIN_DEADTIME, 4, minimum legal measured dead time in cycles
MISMATCH_TIMEOUT, 16, consecutive cycles of filtered feedback differing from command before fault_mismatch sets (must exceed 2+FILTER_COUNT)
CNT_WIDTH, 8, width of dead-time and mismatch counters

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
Q1_cmd  in  1  commanded top-switch gate, synchronous to CLK
Q2_cmd  in  1  commanded bottom-switch gate, synchronous to CLK
Q1_fb  in  1  top gate feedback pin, asynchronous
Q2_fb  in  1  bottom gate feedback pin, asynchronous
fault_clear  in  1  one-cycle request to clear sticky faults
Q1_filt  out  1  filtered top feedback
Q2_filt  out  1  filtered bottom feedback
leg_state  out  2  00 both off, 01 Q2 on, 10 Q1 on, 11 both on
deadtime_meas  out  CNT_WIDTH  last completed dead-time measurement, cycles
deadtime_valid  out  1  one-cycle pulse when deadtime_meas updates
fault_shoot  out  1  sticky shoot-through fault
fault_deadtime  out  1  sticky short-dead-time fault
fault_mismatch  out  1  sticky command/feedback mismatch fault
fault_any  out  1  OR of the three faults, registered

Behaviour:
- Reset (RST_N low, async): sync flops, filters, counters, all outputs = 0; leg_state = 00; FSM = DEAD with last_on = NONE.
- Sync: fixed 2-flop synchronizer per feedback input.
- Filter, per input: counter clears whenever the synced value equals the filtered value. Otherwise it increments. The filtered value flips on the edge where it reaches FILTER_COUNT, and the counter clears. A stable fb change therefore reaches *_filt exactly 2+FILTER_COUNT edges later (5 at default). A pulse of FILTER_COUNT-1 synced cycles or fewer is rejected.
- FSM on (Q1_filt,Q2_filt); states DEAD, LOW, HIGH, SHOOT; leg_state is the registered encoding, updated the same edge as *_filt.
- DEAD: dt counter increments each cycle in DEAD and saturates at 2^CNT_WIDTH-1. It clears when entering DEAD.
- DEAD->LOW with last_on=HIGH, or DEAD->HIGH with last_on=LOW: deadtime_meas <= dt count and deadtime_valid pulses. If count < MIN_DEADTIME, fault_deadtime sets the same edge.
- DEAD exit to the same side as last_on (aborted transition), or with last_on=NONE: no measurement, no pulse.
- LOW/HIGH: last_on updated. Direct LOW<->HIGH with no DEAD cycle: measurement 0, valid pulse, fault_deadtime set.
- Any state -> SHOOT: fault_shoot sets on the edge leg_state becomes 11. From SHOOT, last_on = NONE.
- Mismatch counter increments while {Q1_filt,Q2_filt} != {Q1_cmd,Q2_cmd}, saturating; it clears when they are equal. fault_mismatch sets on the edge the count reaches MISMATCH_TIMEOUT.
- Faults: sticky until fault_clear. A set condition in the same cycle as fault_clear wins, so the fault stays 1. fault_shoot cannot clear while leg_state = 11.
- fault_any: registered OR of the fault registers, so it lags them by one cycle.
- Reset mid-measurement: no deadtime_valid is produced for the interrupted interval.

Test Plan:
- Reset -> all outputs 0, leg_state 00; hold fb both 0, cmd both 0 for 50 cycles -> no faults, no valid pulse.
- Q1_fb=1 for 20 cycles, then 0 for 6 cycles, then Q2_fb=1 with cmd tracking -> deadtime_meas=6 with a 1-cycle deadtime_valid, leg_state sequence 10,00,01, no faults.
- Same sequence with only 2 dead cycles -> deadtime_meas=2, fault_deadtime=1, fault_any=1 one cycle later; fault_clear pulse -> both return to 0.
- Q1_fb pulse of 2 synced cycles -> Q1_filt stays 0; a 3-cycle pulse -> Q1_filt high for 3 cycles, 5 edges after the pin edge.
- Q1_fb and Q2_fb both 1 for 10 cycles -> leg_state 11, fault_shoot=1; fault_clear during overlap -> fault_shoot stays 1; fault_clear after -> 0.
- Q1_cmd=1, Q1_fb held 0 -> fault_mismatch sets on mismatch cycle 16. Mismatch of 15 cycles then match -> no fault. Assert RST_N mid-DEAD -> all cleared, no valid pulse afterwards.
